load_scoreboard: RTL
====================

LOAD_SCOREBOARD -- requirements
Module: load_scoreboard

Interface
REQ-001 Parameter: LQ_DEPTH, 4, number of outstanding loads tracked; power of two, 2..16.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 rs1D, rs2D  in  5 each  source register indices of the instruction in Decode.
REQ-005 use_rs1D, use_rs2D  in  1 each  Decode instruction reads rs1/rs2.
REQ-006 rdD  in  5  destination of the Decode instruction.
REQ-007 reg_writeD  in  1  Decode instruction writes rdD.
REQ-008 mem_loadD  in  3  load type; 3'b000 = not a load.
REQ-009 issueD  in  1  Decode requests advance into Execute.
REQ-010 flushD  in  1  Decode instruction squashed this cycle.
REQ-011 mem_valid  in  1  data memory returns one load result this cycle.
REQ-012 stallD  out  1  hold Decode; Decode instruction not accepted.
REQ-013 resp_rd  out  5  destination of the load being returned; valid when mem_valid and not empty.
REQ-014 lq_count  out  clog2(LQ_DEPTH)+1  outstanding loads.
REQ-015 lq_full, lq_empty  out  1 each  queue status.
REQ-016 resp_err  out  1  sticky: mem_valid seen with empty queue.

Function
REQ-017 is_load = reg_writeD & (mem_loadD != 3'b000); rd 0 loads are still loads.
REQ-018 accept = issueD & ~stallD & ~flushD.
REQ-019 Per-register busy bit (combinational): rN busy iff N != 0 and a valid queue entry holds rd N.
REQ-020 stallD = (use_rs1D & busy[rs1D]) | (use_rs2D & busy[rs2D]) | (is_load & lq_full & ~mem_valid); x0 never stalls.
REQ-021 Entry being popped this cycle still counts as busy; the dependent instruction issues the following cycle, when the writeback forwarding path supplies the data.
REQ-022 On accept with is_load: push rdD at tail; entry visible to busy on the next cycle.
REQ-023 On mem_valid with lq_empty=0: pop head; resp_rd = head rd combinationally in the same cycle.
REQ-024 Push and pop in the same cycle: both happen, count unchanged; allowed when full (hence REQ-020 ~mem_valid term).
REQ-025 Pop with empty queue: no state change except resp_err<=1; resp_rd = 0.
REQ-026 Pointers wrap modulo LQ_DEPTH; count range 0..LQ_DEPTH, never exceeds.
REQ-027 Multiple pending loads to the same rd are permitted; busy clears only when the last matching entry pops (in-order completion).
REQ-028 flushD affects only the Decode instruction; queued entries are never removed except by pop or reset.
REQ-029 Non-load instructions never modify the queue; latency push->visible 1 cycle, pop->not busy 1 cycle.

Reset
REQ-030 rst_n low at rising edge: head, tail, count = 0, all entry valid bits = 0, resp_err = 0.
REQ-031 Post-reset outputs: stallD driven by inputs only (busy all 0), lq_empty=1, lq_full=0, lq_count=0, resp_rd=0.
REQ-032 Reset mid-operation discards outstanding loads; responses arriving after reset set resp_err.

Structure
REQ-033 Shared pipeline package holds: MEM_LOAD_NONE = 3'b000 and load-type encodings, REG_IDX_W = 5, LQ_DEPTH default.
REQ-034 One sub-module: lq_fifo (synchronous FIFO of 5-bit rd with per-entry valid, exposing entry array for busy match).
REQ-035 No latches; busy and stallD purely combinational from registered state and inputs.

Verification
REQ-036 Load x5 accepted, next cycle add reading rs1=x5 -> stallD=1 until mem_valid cycle inclusive; stallD=0 the cycle after; resp_rd=5 on pop.
REQ-037 Fill 4 loads (rd 1,2,3,4), 5th load with mem_valid=0 -> stallD=1, count=4; same with mem_valid=1 -> accepted, count stays 4, resp_rd=1.
REQ-038 Two loads to x7 then one pop -> x7 still busy; second pop -> x7 free next cycle.
REQ-039 Load to x0 -> pushed, count=1, no stall for readers of x0; pop -> resp_rd=0, count=0.
REQ-040 mem_valid with empty queue -> resp_err=1 and holds; rst_n=0 one cycle -> resp_err=0, count=0.
REQ-041 Load with flushD=1 -> not pushed, count unchanged; 6 pushes/pops around pointer wrap -> resp_rd order equals push order.

Source files
------------

// File: rtl/load_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_scoreboard_pkg
// Description : Shared pipeline definitions for the load scoreboard: register
//               index width, load-type encodings and queue depth default.
// Revision    : 1.0 - initial release
// ============================================================================
package load_scoreboard_pkg;

   localparam int REG_IDX_W        = 5;
   localparam int NUM_REGS         = 32;
   localparam int LQ_DEPTH_DEFAULT = 4;

   // Load-type encodings carried on mem_loadD; zero means "not a load".
   localparam logic [2:0] MEM_LOAD_NONE = 3'b000;
   localparam logic [2:0] MEM_LOAD_LB   = 3'b001;
   localparam logic [2:0] MEM_LOAD_LH   = 3'b010;
   localparam logic [2:0] MEM_LOAD_LW   = 3'b011;
   localparam logic [2:0] MEM_LOAD_LBU  = 3'b100;
   localparam logic [2:0] MEM_LOAD_LHU  = 3'b101;

   typedef logic [REG_IDX_W-1:0] regIdx_t;

   // A Decode instruction is a load when it writes a register and carries a
   // load type; rd = x0 loads still count so their responses stay matched.
   function automatic logic isLoadOp(input logic regWrite, input logic [2:0] memLoad);
      return regWrite & (memLoad != MEM_LOAD_NONE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : load_scoreboard_if
// Description : Decode/memory-response bundle between the pipeline (master)
//               and the load scoreboard (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface load_scoreboard_if
   import load_scoreboard_pkg::*;
#(
   parameter int LQ_DEPTH = LQ_DEPTH_DEFAULT
);
   localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

   regIdx_t          rs1D;
   regIdx_t          rs2D;
   logic             use_rs1D;
   logic             use_rs2D;
   regIdx_t          rdD;
   logic             reg_writeD;
   logic [2:0]       mem_loadD;
   logic             issueD;
   logic             flushD;
   logic             mem_valid;
   logic             stallD;
   regIdx_t          resp_rd;
   logic [CNT_W-1:0] lq_count;
   logic             lq_full;
   logic             lq_empty;
   logic             resp_err;

   modport master (
      output rs1D, rs2D, use_rs1D, use_rs2D, rdD, reg_writeD, mem_loadD,
             issueD, flushD, mem_valid,
      input  stallD, resp_rd, lq_count, lq_full, lq_empty, resp_err
   );

   modport slave (
      input  rs1D, rs2D, use_rs1D, use_rs2D, rdD, reg_writeD, mem_loadD,
             issueD, flushD, mem_valid,
      output stallD, resp_rd, lq_count, lq_full, lq_empty, resp_err
   );

endinterface
`default_nettype wire

// File: rtl/load_scoreboard_lq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lq_fifo
// Description : Synchronous FIFO of load destination registers with a valid
//               bit per entry; the entry array is exposed for busy matching.
// Revision    : 1.0 - initial release
// ============================================================================
module lq_fifo
   import load_scoreboard_pkg::*;
#(
   parameter int DEPTH = LQ_DEPTH_DEFAULT,
   parameter int CNT_W = $clog2(DEPTH) + 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  regIdx_t          pushRd,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output regIdx_t          headRd,
   output regIdx_t          entryRd [DEPTH],
   output logic [DEPTH-1:0] entryValid
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   regIdx_t          r_rd [DEPTH];
   logic [DEPTH-1:0] r_valid;

   logic w_doPop;
   logic w_doPush;

   assign full   = (r_count == CNT_W'(DEPTH));
   assign empty  = (r_count == '0);
   assign count  = r_count;
   assign headRd = r_rd[r_head];
   assign entryValid = r_valid;

   // A pop frees a slot in the same cycle, so a push into a full queue is
   // legal only alongside a pop.
   assign w_doPop  = pop & ~empty;
   assign w_doPush = push & (~full | w_doPop);

   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_entry
         assign entryRd[g] = r_rd[g];
      end
   endgenerate

   // Pointer, count and entry updates; on a simultaneous pop/push of the same
   // slot (full queue) the push is written last and wins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_rd[i] <= '0;
         end
      end else begin
         if (w_doPop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PTR_W'(1);
         end
         if (w_doPush) begin
            r_rd[r_tail]    <= pushRd;
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + PTR_W'(1);
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/load_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : load_scoreboard
// Description : Tracks outstanding loads and stalls Decode on a RAW hazard
//               against any pending load destination or on a full queue.
// Revision    : 1.0 - initial release
// ============================================================================
module load_scoreboard
   import load_scoreboard_pkg::*;
#(
   parameter int LQ_DEPTH = LQ_DEPTH_DEFAULT
)(
   input logic              clk,
   input logic              rst_n,
   load_scoreboard_if.slave sb
);
   localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

   logic                w_isLoad;
   logic                w_accept;
   logic                w_push;
   logic                w_full;
   logic                w_empty;
   logic [CNT_W-1:0]    w_count;
   regIdx_t             w_headRd;
   regIdx_t             w_entryRd [LQ_DEPTH];
   logic [LQ_DEPTH-1:0] w_entryValid;
   logic [NUM_REGS-1:0] w_busy;
   logic                r_respErr;

   assign w_isLoad = isLoadOp(sb.reg_writeD, sb.mem_loadD);
   assign w_accept = sb.issueD & ~sb.stallD & ~sb.flushD;
   assign w_push   = w_accept & w_isLoad;

   lq_fifo #(
      .DEPTH (LQ_DEPTH),
      .CNT_W (CNT_W)
   ) u_lqFifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (w_push),
      .pushRd     (sb.rdD),
      .pop        (sb.mem_valid),
      .full       (w_full),
      .empty      (w_empty),
      .count      (w_count),
      .headRd     (w_headRd),
      .entryRd    (w_entryRd),
      .entryValid (w_entryValid)
   );

   // Busy map: a register is busy while any valid entry names it, including
   // the entry being popped this cycle; x0 is never busy.
   always_comb begin
      w_busy = '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
         if (w_entryValid[i]) begin
            w_busy[w_entryRd[i]] = 1'b1;
         end
      end
      w_busy[0] = 1'b0;
   end

   assign sb.stallD = (sb.use_rs1D & w_busy[sb.rs1D])
                    | (sb.use_rs2D & w_busy[sb.rs2D])
                    | (w_isLoad & w_full & ~sb.mem_valid);

   assign sb.resp_rd  = w_empty ? '0 : w_headRd;
   assign sb.lq_count = w_count;
   assign sb.lq_full  = w_full;
   assign sb.lq_empty = w_empty;
   assign sb.resp_err = r_respErr;

   // Sticky flag for a memory response that has no matching outstanding load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_respErr <= 1'b0;
      end else if (sb.mem_valid & w_empty) begin
         r_respErr <= 1'b1;
      end
   end

endmodule
`default_nettype wire
